// File: rtl/audio_pkg.sv
// audio_pkg: shared types and helpers for the audio mixer / PWM output block.
//   mix_state_t : soft-mute state machine states
//   sat_trunc   : unsigned saturation of a value to a given bit width
package audio_pkg;

  typedef enum logic [1:0] {
    SILENT = 2'd0,
    RUN    = 2'd1,
    FADE   = 2'd2
  } mix_state_t;

  localparam int unsigned PWM_W_DEFAULT        = 8;
  localparam int unsigned VOL_W                = 4;
  localparam int unsigned FADE_PERIODS_DEFAULT = 16;

  function automatic logic [31:0] sat_trunc(input logic [31:0] value,
                                            input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/audio_mixer_pwm_core.sv
// pwm_core: free-running PWM carrier with a per-period duty latch.
//   clk, rst_n  : clock, asynchronous active-low reset
//   level       : duty value sampled on the last cycle of each period
//   boundary    : high on the last cycle of each period (pwm_cnt all-ones)
//   period_tick : registered one-cycle pulse on the first cycle of a period
//   pwm_out     : registered PWM output, high while pwm_cnt < duty_q
module pwm_core
  import audio_pkg::*;
#(
  parameter int unsigned PWM_W = PWM_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] level,
  output logic             boundary,
  output logic             period_tick,
  output logic             pwm_out
);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_q;

  assign boundary = (pwm_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt     <= '0;
      duty_q      <= '0;
      period_tick <= 1'b0;
      pwm_out     <= 1'b0;
    end else begin
      pwm_cnt     <= pwm_cnt + PWM_W'(1);
      period_tick <= boundary;
      if (boundary) begin
        duty_q <= level;
      end
      pwm_out <= (pwm_cnt < duty_q);
    end
  end

endmodule

// File: rtl/audio_mixer_pwm.sv
// audio_mixer_pwm: weighted mix of 1-bit tone channels, volume scaling with
// soft-mute fade, and single-pin PWM output.
//   clk, rst_n   : clock, asynchronous active-low reset
//   ch_in/ch_en  : tone inputs and per-channel enables
//   ch_weight    : packed per-channel weights, channel i at [i*WEIGHT_W +: WEIGHT_W]
//   master_vol   : master volume 0..15
//   mute         : soft-mute request level
//   pwm_out      : PWM audio output
//   period_tick  : pulse on the first cycle of each PWM period
//   audio_active : high in RUN or FADE
module audio_mixer_pwm
  import audio_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned WEIGHT_W     = 4,
  parameter int unsigned PWM_W        = PWM_W_DEFAULT,
  parameter int unsigned FADE_PERIODS = FADE_PERIODS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_in,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH*WEIGHT_W-1:0]   ch_weight,
  input  logic [VOL_W-1:0]             master_vol,
  input  logic                         mute,
  output logic                         pwm_out,
  output logic                         period_tick,
  output logic                         audio_active
);

  localparam int unsigned SUM_W  = WEIGHT_W + $clog2(NUM_CH);
  localparam int unsigned PROD_W = SUM_W + VOL_W;
  localparam int unsigned FC_W   = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;

  logic [SUM_W-1:0]  sum_d;
  logic [SUM_W-1:0]  sum_q;
  logic [PROD_W-1:0] prod;
  logic [PWM_W-1:0]  lvl_d;
  logic [PWM_W-1:0]  lvl_q;
  logic              boundary;

  mix_state_t        state;
  mix_state_t        state_nxt;
  logic [VOL_W-1:0]  eff_vol;
  logic [VOL_W-1:0]  vol_nxt;
  logic [FC_W-1:0]   fade_cnt;
  logic [FC_W-1:0]   fcnt_nxt;

  // Mix pipeline: runs every cycle regardless of state.
  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_in[i] && ch_en[i]) begin
        sum_d = sum_d + SUM_W'(ch_weight[i*WEIGHT_W +: WEIGHT_W]);
      end
    end
  end

  assign prod  = PROD_W'(sum_q) * PROD_W'(eff_vol);
  assign lvl_d = PWM_W'(sat_trunc(32'(prod), PWM_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      lvl_q <= '0;
    end else begin
      sum_q <= sum_d;
      lvl_q <= lvl_d;
    end
  end

  // Soft-mute FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SILENT;
      eff_vol  <= '0;
      fade_cnt <= '0;
    end else begin
      state    <= state_nxt;
      eff_vol  <= vol_nxt;
      fade_cnt <= fcnt_nxt;
    end
  end

  // Soft-mute FSM: next state. Everything advances only on period boundaries.
  always_comb begin
    state_nxt = state;
    vol_nxt   = eff_vol;
    fcnt_nxt  = fade_cnt;
    if (boundary) begin
      unique case (state)
        SILENT: begin
          vol_nxt = '0;
          if (!mute) begin
            state_nxt = RUN;
            vol_nxt   = master_vol;
          end
        end
        RUN: begin
          vol_nxt = master_vol;
          if (mute) begin
            state_nxt = FADE;
            fcnt_nxt  = '0;
          end
        end
        FADE: begin
          if (!mute) begin
            state_nxt = RUN;
            vol_nxt   = master_vol;
          end else if (eff_vol == '0) begin
            state_nxt = SILENT;
          end else if (fade_cnt == FC_W'(FADE_PERIODS - 1)) begin
            // Step down; leave straight to SILENT on the step that reaches 0.
            fcnt_nxt = '0;
            vol_nxt  = eff_vol - VOL_W'(1);
            if (eff_vol == VOL_W'(1)) begin
              state_nxt = SILENT;
            end
          end else begin
            fcnt_nxt = fade_cnt + FC_W'(1);
          end
        end
        default: begin
          state_nxt = SILENT;
          vol_nxt   = '0;
          fcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Soft-mute FSM: outputs.
  always_comb begin
    audio_active = (state != SILENT);
  end

  pwm_core #(
    .PWM_W (PWM_W)
  ) u_pwm_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .level       (lvl_q),
    .boundary    (boundary),
    .period_tick (period_tick),
    .pwm_out     (pwm_out)
  );

endmodule

// File: tb/tb_audio_mixer_pwm.sv
// Self-checking bench for audio_mixer_pwm: counts pwm_out high cycles over each
// PWM period and compares against a per-period behavioural model.
module tb_audio_mixer_pwm;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ch_in;
  logic [3:0]  ch_en;
  logic [15:0] ch_weight;
  logic [3:0]  master_vol;
  logic        mute;
  logic        pwm_out;
  logic        period_tick;
  logic        audio_active;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-period model state
  bit m_on;
  bit m_fading;
  int m_vol;
  int m_fade_n;
  int cur_exp;

  audio_mixer_pwm #(
    .NUM_CH       (4),
    .WEIGHT_W     (4),
    .PWM_W        (8),
    .FADE_PERIODS (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_in        (ch_in),
    .ch_en        (ch_en),
    .ch_weight    (ch_weight),
    .master_vol   (master_vol),
    .mute         (mute),
    .pwm_out      (pwm_out),
    .period_tick  (period_tick),
    .audio_active (audio_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int mix_sum(input logic [3:0] i_in, input logic [3:0] i_en,
                                 input logic [15:0] i_w);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++)
      if (i_in[k] && i_en[k]) s += int'(i_w[k*4 +: 4]);
    return s;
  endfunction

  function automatic int level_of(input int s, input int v);
    return (s * v > 255) ? 255 : s * v;
  endfunction

  task automatic model_reset();
    m_on = 1'b0; m_fading = 1'b0; m_vol = 0; m_fade_n = 0; cur_exp = 0;
  endtask

  // One period boundary: duty latches the level built from the old volume,
  // then the mute/volume rules advance.
  task automatic model_boundary();
    cur_exp = level_of(mix_sum(ch_in, ch_en, ch_weight), m_vol);
    if (!m_on) begin
      if (!mute) begin m_on = 1'b1; m_fading = 1'b0; m_vol = int'(master_vol); end
    end else if (!m_fading) begin
      m_vol = int'(master_vol);
      if (mute) begin m_fading = 1'b1; m_fade_n = 0; end
    end else if (!mute) begin
      m_fading = 1'b0; m_vol = int'(master_vol);
    end else if (m_vol == 0) begin
      m_on = 1'b0; m_fading = 1'b0;
    end else begin
      m_fade_n++;
      if (m_fade_n == 16) begin
        m_fade_n = 0;
        m_vol--;
        if (m_vol == 0) begin m_on = 1'b0; m_fading = 1'b0; end
      end
    end
  endtask

  task automatic release_reset();
    int lat;
    lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (period_tick) begin lat = c; break; end
    end
    check("first_tick_latency", lat, 256);
    model_boundary();
  endtask

  // Entered on the first cycle of a period; new inputs land mid-period and
  // stay put through the closing boundary.
  task automatic run_period(input logic [3:0] n_in, input logic [3:0] n_en,
                            input logic [15:0] n_w, input logic [3:0] n_mv,
                            input logic n_mute);
    int highs;
    int chg_at;
    highs  = 0;
    chg_at = int'($urandom_range(200, 8));
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) check("audio_active", int'(audio_active), int'(m_on));
      if (i == 1) check("tick_width", int'(period_tick), 0);
      highs += int'(pwm_out);
      if (i == chg_at) begin
        ch_in = n_in; ch_en = n_en; ch_weight = n_w;
        master_vol = n_mv; mute = n_mute;
      end
    end
    check("period_high_count", highs, cur_exp);
    @(negedge clk);
    check("period_tick", int'(period_tick), 1);
    model_boundary();
  endtask

  initial begin
    int n;
    logic [15:0] w;
    rst_n = 1'b0; mute = 1'b0;
    ch_in = '1; ch_en = '1; ch_weight = '1; master_vol = '1;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_period_tick", int'(period_tick), 0);
    check("rst_audio_active", int'(audio_active), 0);
    release_reset();

    // Single channel, plus an enabled-off channel that must add nothing
    for (int p = 0; p < 4; p++)
      run_period(4'b0011, 4'b0001, 16'h0058, 4'd4, 1'b0);

    // Saturation: 60 * 15 clamps to 255
    for (int p = 0; p < 3; p++)
      run_period(4'b1111, 4'b1111, 16'hFFFF, 4'd15, 1'b0);

    // Asynchronous reset mid-period
    repeat (10) @(negedge clk);
    check("pre_rst_pwm_out", int'(pwm_out), (cur_exp > 9) ? 1 : 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm_out", int'(pwm_out), 0);
    check("async_rst_active", int'(audio_active), 0);
    model_reset();
    release_reset();

    // Random mixes, unmuted
    for (int p = 0; p < 20; p++)
      run_period(4'($urandom), 4'($urandom), 16'($urandom), 4'($urandom), 1'b0);

    // Fade from volume 3 while master_vol wanders
    w = 16'($urandom) | 16'h1111;
    run_period(4'b1111, 4'b1111, w, 4'd3, 1'b0);
    run_period(4'b1111, 4'b1111, w, 4'd3, 1'b0);
    run_period(4'b1111, 4'b1111, w, 4'd3, 1'b1);
    n = 0;
    while (audio_active && n < 60) begin
      run_period(4'b1111, 4'b1111, w, 4'($urandom), 1'b1);
      n++;
    end
    check("fade_length_periods", n, 48);
    run_period(4'b1111, 4'b1111, w, 4'd7, 1'b1);
    run_period(4'b1111, 4'b1111, w, 4'd7, 1'b1);

    // Unmute mid-fade at volume 2
    run_period(4'b1111, 4'b1111, w, 4'd3, 1'b0);
    run_period(4'b1111, 4'b1111, w, 4'd3, 1'b0);
    run_period(4'b1111, 4'b1111, w, 4'd3, 1'b1);
    n = 0;
    while (m_vol != 2 && n < 40) begin
      run_period(4'b1111, 4'b1111, w, 4'd3, 1'b1);
      n++;
    end
    check("fade_reached_vol2", n, 16);
    for (int p = 0; p < 3; p++)
      run_period(4'b1111, 4'b1111, w, 4'd9, 1'b0);

    // Random mixes with occasional mute toggles
    for (int p = 0; p < 60; p++)
      run_period(4'($urandom), 4'($urandom), 16'($urandom), 4'($urandom),
                 ($urandom_range(9, 0) == 0) ? ~mute : mute);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
